// File: rtl/tinyarch_fetch.sv
// Instruction fetch stage: PC, instruction-memory read port and a 2-entry decode queue.
// Optional perf counters are compiled in when FETCH_PERF_EN is defined.
module tinyarch_fetch #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    INSTR_WIDTH = 9,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req,
   output logic                   ack,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic                   imem_rd,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   br_taken,
   input  logic [ADDR_WIDTH-1:0]  br_target,
   input  logic                   halt,
   output logic [15:0]            perf_fetch,
   output logic [15:0]            perf_flush
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  pc, last_addr, infl_pc;
   logic                   inflight, infl_kill;
   logic [1:0]             count;
   logic [INSTR_WIDTH-1:0] q_instr [2];
   logic [ADDR_WIDTH-1:0]  q_pc    [2];

   logic       xfer, halt_xfer, redirect, issue, resp, push, pop, start;
   logic [2:0] occ;

   assign instr_valid = (count != 2'd0);
   assign instr_o     = q_instr[0];
   assign pc_o        = q_pc[0];
   assign imem_rd     = issue;
   assign imem_addr   = issue ? pc : last_addr;

   always_comb begin
      xfer      = instr_valid & instr_ready;
      halt_xfer = xfer & halt;
      redirect  = xfer & br_taken & ~halt;
      start     = (state == IDLE) & req;
      occ       = {1'b0, count} + {2'b0, inflight};
      // A read may still go out in the redirect cycle; it is marked killed and counted as flushed.
      issue     = (state == RUN) & ~halt_xfer &
                  ((occ < 3'd2) | ((occ == 3'd2) & xfer));
      resp      = inflight & ~infl_kill & (state == RUN);
      push      = resp & ~redirect & ~halt_xfer;
      pop       = xfer;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req)       state_nxt = RUN;
         RUN:     if (halt_xfer) state_nxt = DONE;
         DONE:    if (!req)      state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack        <= 1'b0;
         pc         <= START_ADDR;
         last_addr  <= '0;
         infl_pc    <= '0;
         inflight   <= 1'b0;
         infl_kill  <= 1'b0;
         count      <= 2'd0;
         q_instr[0] <= '0;
         q_instr[1] <= '0;
         q_pc[0]    <= '0;
         q_pc[1]    <= '0;
      end else begin
         state     <= state_nxt;
         ack       <= (state_nxt == DONE);
         inflight  <= issue;
         infl_kill <= issue & redirect;
         if (issue) begin
            infl_pc   <= pc;
            last_addr <= pc;
         end

         if (start) begin
            pc    <= START_ADDR;
            count <= 2'd0;
         end else if (redirect) begin
            pc    <= br_target;
            count <= 2'd0;
         end else if (halt_xfer) begin
            count <= 2'd0;
         end else begin
            if (issue)
               pc <= pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            case ({pop, push})
               2'b11: begin
                  if (count == 2'd1) begin
                     q_instr[0] <= imem_data;
                     q_pc[0]    <= infl_pc;
                  end else begin
                     q_instr[0] <= q_instr[1];
                     q_pc[0]    <= q_pc[1];
                     q_instr[1] <= imem_data;
                     q_pc[1]    <= infl_pc;
                  end
               end
               2'b10: begin
                  q_instr[0] <= q_instr[1];
                  q_pc[0]    <= q_pc[1];
                  count      <= count - 2'd1;
               end
               2'b01: begin
                  if (count == 2'd0) begin
                     q_instr[0] <= imem_data;
                     q_pc[0]    <= infl_pc;
                  end else begin
                     q_instr[1] <= imem_data;
                     q_pc[1]    <= infl_pc;
                  end
                  count <= count + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt, flush_cnt;
   logic [1:0]  flush_n;
   logic [16:0] flush_sum;

   // Discards on redirect: queue entries behind the head, the live response, and this cycle's read.
   always_comb begin
      flush_n   = (count - 2'd1) + {1'b0, resp} + {1'b0, issue};
      flush_sum = {1'b0, flush_cnt} + {15'b0, flush_n};
   end

   always_ff @(posedge clk) begin
      if (reset || start) begin
         fetch_cnt <= 16'h0;
         flush_cnt <= 16'h0;
      end else begin
         if (issue && fetch_cnt != 16'hFFFF)
            fetch_cnt <= fetch_cnt + 16'h1;
         if (redirect)
            flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end
   end

   assign perf_fetch = fetch_cnt;
   assign perf_flush = flush_cnt;
`else
   assign perf_fetch = 16'h0;
   assign perf_flush = 16'h0;
`endif

endmodule

// File: tb/tb_tinyarch_fetch.sv
// Directed bench for tinyarch_fetch: streaming, stall, redirect, PC wrap, halt and reset-in-flight.
module tb_tinyarch_fetch;

   logic        clk = 1'b0;
   logic        reset, req, instr_ready, br_taken, halt;
   logic [15:0] br_target;
   logic        ack, imem_rd, instr_valid;
   logic [15:0] imem_addr, pc_o, perf_fetch, perf_flush;
   logic [8:0]  imem_data, instr_o;

   // second instance exercises a non-zero START_ADDR near the wrap point
   logic        req2, ready2, zero_bit;
   logic [15:0] zero_addr;
   logic        ack2, imem_rd2, instr_valid2;
   logic [15:0] imem_addr2, pc_o2, perf_fetch2, perf_flush2;
   logic [8:0]  imem_data2, instr_o2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] xfer_pc  [$];
   logic [8:0]  xfer_ins [$];

`ifdef FETCH_PERF_EN
   localparam int EXP_FLUSH = 2;
   localparam int EXP_FETCH = 8;
`else
   localparam int EXP_FLUSH = 0;
   localparam int EXP_FETCH = 0;
`endif

   always #5 clk = ~clk;

   tinyarch_fetch dut (
      .clk(clk), .reset(reset), .req(req), .ack(ack),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
      .instr_o(instr_o), .pc_o(pc_o), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
      .halt(halt), .perf_fetch(perf_fetch), .perf_flush(perf_flush)
   );

   tinyarch_fetch #(.START_ADDR(16'hFFFE)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .ack(ack2),
      .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(imem_data2),
      .instr_o(instr_o2), .pc_o(pc_o2), .instr_valid(instr_valid2),
      .instr_ready(ready2), .br_taken(zero_bit), .br_target(zero_addr),
      .halt(zero_bit), .perf_fetch(perf_fetch2), .perf_flush(perf_flush2)
   );

   function automatic logic [8:0] mem_word(input logic [15:0] a);
      mem_word = a[8:0] ^ 9'h0A5;
   endfunction

   always @(posedge clk) begin
      if (imem_rd)  imem_data  <= mem_word(imem_addr);
      if (imem_rd2) imem_data2 <= mem_word(imem_addr2);
   end

   always @(posedge clk) begin
      if (!reset && instr_valid && instr_ready) begin
         xfer_pc.push_back(pc_o);
         xfer_ins.push_back(instr_o);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ack"},     ack,         0);
      chk({tag, " rd"},      imem_rd,     0);
      chk({tag, " valid"},   instr_valid, 0);
      chk({tag, " addr"},    imem_addr,   0);
      chk({tag, " instr"},   instr_o,     0);
      chk({tag, " pc"},      pc_o,        0);
      chk({tag, " pfetch"},  perf_fetch,  0);
      chk({tag, " pflush"},  perf_flush,  0);
      chk({tag, " valid2"},  instr_valid2, 0);
      chk({tag, " pc2"},     pc_o2,       0);
   endtask

   logic [15:0] exp_pcs [8];

   initial begin
      reset = 1'b1; req = 1'b0; req2 = 1'b0; instr_ready = 1'b0;
      br_taken = 1'b0; br_target = 16'h0; halt = 1'b0;
      ready2 = 1'b1; zero_bit = 1'b0; zero_addr = 16'h0;
      imem_data = '0; imem_data2 = '0;
      step; step;
      chk_reset_vals("reset");

      // streaming from START_ADDR
      reset = 1'b0; req = 1'b1; req2 = 1'b1; instr_ready = 1'b1;
      step; #1;
      chk("c1 rd", imem_rd, 1);
      chk("c1 addr", imem_addr, 16'h0);
      chk("c1 valid", instr_valid, 0);
      step; #1;
      chk("c2 valid", instr_valid, 0);
      step; #1;
      chk("c3 valid", instr_valid, 1);
      chk("c3 pc", pc_o, 16'h0);
      chk("c3 instr", instr_o, mem_word(16'h0));
      chk("wrap pc0", pc_o2, 16'hFFFE);
      step; #1;
      chk("c4 pc", pc_o, 16'h1);
      chk("c4 instr", instr_o, mem_word(16'h1));
      chk("wrap pc1", pc_o2, 16'hFFFF);
      step; #1;
      chk("c5 pc", pc_o, 16'h2);
      chk("wrap pc2", pc_o2, 16'h0000);
      chk("wrap instr2", instr_o2, mem_word(16'h0000));

      // stall with a full queue
      step; instr_ready = 1'b0; #1;
      chk("c6 pc", pc_o, 16'h3);
      chk("c6 rd", imem_rd, 0);
      for (int i = 0; i < 4; i++) begin
         step; #1;
         chk("stall rd", imem_rd, 0);
         chk("stall valid", instr_valid, 1);
         chk("stall pc", pc_o, 16'h3);
         chk("stall instr", instr_o, mem_word(16'h3));
      end
      step; instr_ready = 1'b1; #1;
      chk("rel pc", pc_o, 16'h3);
      chk("rel rd", imem_rd, 1);
      chk("rel addr", imem_addr, 16'h5);
      step; #1;
      chk("rel pc4", pc_o, 16'h4);

      // redirect on the transfer of pc 5
      step; br_taken = 1'b1; br_target = 16'h0040; #1;
      chk("br pc5", pc_o, 16'h5);
      step; br_taken = 1'b0; #1;
      chk("br valid0", instr_valid, 0);
      chk("br rd tgt", imem_rd, 1);
      chk("br addr tgt", imem_addr, 16'h0040);
      chk("br pflush", perf_flush, EXP_FLUSH);
      chk("br pfetch", perf_fetch, EXP_FETCH);
      step; #1;
      chk("br valid1", instr_valid, 0);
      step; #1;
      chk("br valid2", instr_valid, 1);
      chk("br pc tgt", pc_o, 16'h0040);
      chk("br instr tgt", instr_o, mem_word(16'h0040));

      // halt together with br_taken: halt wins
      step; halt = 1'b1; br_taken = 1'b1; br_target = 16'h0080; #1;
      chk("halt pc", pc_o, 16'h0041);
      step; halt = 1'b0; br_taken = 1'b0; #1;
      chk("halt ack", ack, 1);
      chk("halt rd", imem_rd, 0);
      chk("halt valid", instr_valid, 0);
      chk("halt addr hold", imem_addr, 16'h0042);
      step; req = 1'b0; #1;
      chk("done ack hold", ack, 1);
      step; #1;
      chk("idle ack", ack, 0);
      chk("idle rd", imem_rd, 0);

      // every fetched word reached decode exactly once, redirect shadow excluded
      exp_pcs = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h40, 16'h41};
      chk("xfer count", xfer_pc.size(), 8);
      for (int i = 0; i < 8 && i < xfer_pc.size(); i++) begin
         chk("xfer pc", xfer_pc[i], exp_pcs[i]);
         chk("xfer instr", xfer_ins[i], mem_word(exp_pcs[i]));
      end

      // reset with a read in flight
      req = 1'b1;
      step; #1;
      chk("rst run rd", imem_rd, 1);
      step; reset = 1'b1; #1;
      step; #1;
      chk_reset_vals("rst flight");
      reset = 1'b0; req = 1'b0;
      step; #1;
      chk("post rst valid", instr_valid, 0);
      step; #1;
      chk("post rst valid2", instr_valid, 0);
      chk("post rst pc", pc_o, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
